four_to_two_request_encoder: RTL and testbench

Registered 4-to-2 request encoder: the encode-side counterpart of the 2-to-4 decoder. It captures a 4-bit request vector into a pending mask and presents one 2-bit index at a time through a valid/ready handshake, selecting by round-robin or fixed priority. It sits between per-unit request lines and any consumer that needs a binary unit index, such as a register-file port select or stall/forward source select.

---
 rtl/four_to_two_request_encoder.sv | 107 ++++++++++
 tb/tb_four_to_two_request_encoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/four_to_two_request_encoder.sv
`default_nettype none
// ============================================================================
// Module      : four_to_two_request_encoder
// Description : Registered 4-to-2 request encoder. Request events are captured
//               into a pending mask. One 2-bit source index at a time is then
//               presented through a valid/ready output stage. The index is
//               chosen by round-robin or by fixed priority (lowest index wins).
// Ports       : clk          - clock, all state updates on the rising edge
//               reset_n      - synchronous active-low reset
//               enable       - 1 = capture req this cycle
//               req[3:0]     - request events, one bit per source
//               out_ready    - consumer accepts out_idx this cycle
//               out_valid    - out_idx holds a valid index (registered)
//               out_idx[1:0] - encoded source index (registered)
//               pending[3:0] - captured requests not yet loaded (registered)
//               grant_count  - accepted handshakes mod 2^CNT_W (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module four_to_two_request_encoder #(
  parameter int RR_ENABLE = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [3:0]       req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [1:0]       out_idx,
  output logic [3:0]       pending,
  output logic [CNT_W-1:0] grant_count
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0] ptr;
  logic [1:0] search_base;
  logic [1:0] cand;
  logic [1:0] pick_idx;
  logic       pick_found;
  logic       stage_free;
  logic       do_load;
  logic       do_accept;
  logic [3:0] load_mask;
  logic [3:0] req_in;

  // Fixed priority is a round-robin search that always starts at index 0.
  assign search_base = (RR_ENABLE != 0) ? ptr : 2'd0;

  // Walk the four candidates starting at search_base; the first set bit wins.
  always_comb begin
    pick_idx   = 2'd0;
    pick_found = 1'b0;
    cand       = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = search_base + 2'(k);
      if (!pick_found && pending[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign stage_free = !out_valid || out_ready;
  assign do_load    = stage_free && pick_found;
  assign do_accept  = out_valid && out_ready;
  assign load_mask  = do_load ? (4'b0001 << pick_idx) : 4'b0000;
  assign req_in     = enable ? req : 4'b0000;

  // The new request is OR-ed in after the loaded bit is cleared, so a source
  // re-requesting in its own load cycle is serviced again later.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending     <= 4'b0000;
      out_valid   <= 1'b0;
      out_idx     <= 2'b00;
      grant_count <= '0;
    end else begin
      pending <= (pending & ~load_mask) | req_in;
      if (stage_free) begin
        out_valid <= pick_found;
        if (pick_found) begin
          out_idx <= pick_idx;
        end
      end
      if (do_accept) begin
        grant_count <= grant_count + c_cnt_one;
      end
    end
  end

  generate
    if (RR_ENABLE != 0) begin : g_rr_ptr
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          ptr <= 2'd0;
        end else if (do_load) begin
          ptr <= pick_idx + 2'd1;
        end
      end
    end else begin : g_fixed_ptr
      assign ptr = 2'd0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_four_to_two_request_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_four_to_two_request_encoder
// Description : Self-checking bench. Three encoder instances (round-robin,
//               fixed priority, 2-bit counter) share one stimulus stream and
//               are compared every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_four_to_two_request_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       enable;
  logic [3:0] req;
  logic       out_ready;

  logic       v0, v1, v2;
  logic [1:0] i0, i1, i2;
  logic [3:0] p0, p1, p2;
  logic [7:0] g0, g1;
  logic [1:0] g2;

  int vectors     = 0;
  int miscompares = 0;

  four_to_two_request_encoder #(.RR_ENABLE(1), .CNT_W(8)) dut_rr (
    .clk(clk), .reset_n(reset_n), .enable(enable), .req(req), .out_ready(out_ready),
    .out_valid(v0), .out_idx(i0), .pending(p0), .grant_count(g0));

  four_to_two_request_encoder #(.RR_ENABLE(0), .CNT_W(8)) dut_fp (
    .clk(clk), .reset_n(reset_n), .enable(enable), .req(req), .out_ready(out_ready),
    .out_valid(v1), .out_idx(i1), .pending(p1), .grant_count(g1));

  four_to_two_request_encoder #(.RR_ENABLE(1), .CNT_W(2)) dut_c2 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .req(req), .out_ready(out_ready),
    .out_valid(v2), .out_idx(i2), .pending(p2), .grant_count(g2));

  // Reference model state per instance, plain integers.
  int RR[3] = '{1, 0, 1};
  int CW[3] = '{8, 8, 2};
  int m_pend[3];
  int m_valid[3];
  int m_idx[3];
  int m_ptr[3];
  int m_cnt[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  function automatic void model_step();
    for (int n = 0; n < 3; n++) begin
      bit acc;
      bit free_st;
      bit found;
      int pick;
      int c;
      int nxt;
      if (!reset_n) begin
        m_pend[n]  = 0;
        m_valid[n] = 0;
        m_idx[n]   = 0;
        m_ptr[n]   = 0;
        m_cnt[n]   = 0;
      end else begin
        acc     = (m_valid[n] != 0) && out_ready;
        free_st = (m_valid[n] == 0) || out_ready;
        found   = 0;
        pick    = 0;
        for (int k = 0; k < 4; k++) begin
          c = (RR[n] != 0) ? (m_ptr[n] + k) % 4 : k;
          if (!found && ((m_pend[n] >> c) & 1) != 0) begin
            found = 1;
            pick  = c;
          end
        end
        nxt = m_pend[n];
        if (free_st) begin
          if (found) begin
            m_valid[n] = 1;
            m_idx[n]   = pick;
            nxt        = nxt & ~(1 << pick);
            if (RR[n] != 0) m_ptr[n] = (pick + 1) % 4;
          end else begin
            m_valid[n] = 0;
          end
        end
        if (enable) nxt = nxt | int'(req);
        m_pend[n] = nxt & 15;
        if (acc) m_cnt[n] = (m_cnt[n] + 1) % (1 << CW[n]);
      end
    end
  endfunction

  task automatic check_all();
    chk("rr_valid",   32'(v0), 32'(m_valid[0]));
    chk("rr_idx",     32'(i0), 32'(m_idx[0]));
    chk("rr_pending", 32'(p0), 32'(m_pend[0]));
    chk("rr_count",   32'(g0), 32'(m_cnt[0]));
    chk("fp_valid",   32'(v1), 32'(m_valid[1]));
    chk("fp_idx",     32'(i1), 32'(m_idx[1]));
    chk("fp_pending", 32'(p1), 32'(m_pend[1]));
    chk("fp_count",   32'(g1), 32'(m_cnt[1]));
    chk("c2_valid",   32'(v2), 32'(m_valid[2]));
    chk("c2_idx",     32'(i2), 32'(m_idx[2]));
    chk("c2_pending", 32'(p2), 32'(m_pend[2]));
    chk("c2_count",   32'(g2), 32'(m_cnt[2]));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b1;
    req       = 4'b1111;
    out_ready = 1'b0;

    // Reset held two cycles with requests present, then idle.
    step();
    step();
    chk("reset_valid",   32'(v0), 32'd0);
    chk("reset_pending", 32'(p0), 32'd0);
    chk("reset_count",   32'(g0), 32'd0);
    chk("reset_idx",     32'(i0), 32'd0);
    reset_n = 1'b1;
    enable  = 1'b0;
    step();
    step();
    chk("idle_pending", 32'(p0), 32'd0);
    chk("idle_valid",   32'(v0), 32'd0);

    // Round-robin burst: one capture of 1011, indices 0,1,3.
    enable    = 1'b1;
    req       = 4'b1011;
    out_ready = 1'b1;
    step();
    chk("burst_capture", 32'(p0), 32'hb);
    enable = 1'b0;
    step();
    chk("burst_v1", 32'(v0), 32'd1);
    chk("burst_i1", 32'(i0), 32'd0);
    step();
    chk("burst_i2", 32'(i0), 32'd1);
    step();
    chk("burst_i3", 32'(i0), 32'd3);
    step();
    chk("burst_end_valid", 32'(v0), 32'd0);
    chk("burst_count",     32'(g0), 32'd3);

    // Fairness: 1111 every cycle; round-robin rotates, fixed priority sticks at 0.
    enable = 1'b1;
    req    = 4'b1111;
    step();
    for (int n = 0; n < 10; n++) begin
      step();
      chk("fair_idx",     32'(i0), 32'(n % 4));
      chk("fp_idx_zero",  32'(i1), 32'd0);
      chk("fp_upper_set", 32'(p1[3:1]), 32'h7);
    end

    // Backpressure: 0110 captured, index 1 held while out_ready=0.
    reset_n = 1'b0;
    step();
    reset_n   = 1'b1;
    out_ready = 1'b0;
    req       = 4'b0110;
    step();
    enable = 1'b0;
    for (int n = 0; n < 5; n++) begin
      step();
      chk("bp_idx",     32'(i0), 32'd1);
      chk("bp_valid",   32'(v0), 32'd1);
      chk("bp_pending", 32'(p0), 32'h4);
    end
    out_ready = 1'b1;
    step();
    chk("bp_next_idx", 32'(i0), 32'd2);
    chk("bp_count1",   32'(g0), 32'd1);
    step();
    chk("bp_count2", 32'(g0), 32'd2);

    // enable=0 ignores requests.
    req = 4'b1111;
    step();
    step();
    chk("en_off_pending", 32'(p0), 32'd0);

    // Reset while an index is in flight: dropped, not counted.
    enable    = 1'b1;
    req       = 4'b0001;
    out_ready = 1'b0;
    step();
    enable = 1'b0;
    step();
    chk("inflight_valid", 32'(v0), 32'd1);
    reset_n   = 1'b0;
    out_ready = 1'b1;
    step();
    chk("rst_mid_valid", 32'(v0), 32'd0);
    chk("rst_mid_count", 32'(g0), 32'd0);
    chk("rst_mid_idx",   32'(i0), 32'd0);

    // Five accepts: 8-bit counter reads 5, 2-bit counter wraps to 1.
    reset_n = 1'b1;
    enable  = 1'b1;
    req     = 4'b1111;
    step();
    step();
    enable = 1'b0;
    for (int n = 0; n < 5; n++) step();
    chk("wrap_count8", 32'(g0), 32'd5);
    chk("wrap_count2", 32'(g2), 32'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      reset_n   = ($urandom_range(0, 29) != 0);
      enable    = $urandom_range(0, 1) == 1;
      req       = 4'($urandom_range(0, 15));
      out_ready = $urandom_range(0, 3) != 0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
